hazard_stall_ctrl: RTL

// - Pipeline sequencing controller for the 5-stage MIPS-Lite core. Sits beside the IF/ID,
//   ID/EX, EX/MEM and MEM/WB registers and drives their write-enable and bubble controls.
// - Covers load-use stalls, taken-branch flushes and data-memory wait-state freezes.
// - Adds a memory-wait watchdog and saturating performance counters.

---
 rtl/hazard_stall_ctrl_pkg.sv | 29 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the MIPS-Lite pipeline sequencing controller:
// FSM encodings, default register-specifier width and the pipeline control bundle.
package hazard_stall_ctrl_pkg;

  localparam int HSC_REG_W = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NORMAL = 8'b1101_0100;
  localparam pipe_ctrl_t CTRL_QUIET  = 8'b0010_1011;
  localparam pipe_ctrl_t CTRL_ERR    = 8'b0000_1011;
  localparam pipe_ctrl_t CTRL_FREEZE = 8'b0000_0001;
  localparam pipe_ctrl_t CTRL_FLUSH  = 8'b1111_1110;
  localparam pipe_ctrl_t CTRL_STALL  = 8'b0001_1100;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, dmem wait freezes,
// a wait-state watchdog and saturating performance counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W        = HSC_REG_W,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_br_taken,
  input  logic             exmem_MemAcc,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt_tot
);

  localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_ctr_q, wait_ctr_d;
  logic            err_q, err_d;

  logic       freeze, flush, load_use, live;
  pipe_ctrl_t ctrl;

  always_comb begin
    live     = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    freeze   = live && exmem_MemAcc && !dmem_ready;
    flush    = live && exmem_br_taken && !freeze;
    // Register $0 is hard-wired, so a load targeting it can never create a hazard.
    load_use = live && idex_MemRead && (idex_rt != {REG_W{1'b0}}) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt))) &&
               !freeze && !flush;
  end

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (!rst) begin
      ctrl = CTRL_QUIET;
    end else if (!live) begin
      ctrl = CTRL_ERR;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (flush) begin
      ctrl = CTRL_FLUSH;
    end else if (load_use) begin
      ctrl = CTRL_STALL;
    end else begin
      ctrl = CTRL_NORMAL;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_write  = ctrl.exmem_write;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign err          = err_q;

  always_comb begin
    state_d    = state_q;
    wait_ctr_d = wait_ctr_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_ctr_d = WC_ONE;
        end else begin
          state_d    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze && (wait_ctr_q == WC_LAST)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (freeze) begin
          wait_ctr_d = wait_ctr_q + WC_ONE;
        end else begin
          state_d    = ST_RUN;
          wait_ctr_d = {WC_W{1'b0}};
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      // An unreachable encoding is treated like a watchdog trip.
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_ctr_q <= {WC_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_ctr_q <= wait_ctr_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk), .rst_ni(rst), .inc_i(load_use), .cnt_o(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk), .rst_ni(rst), .inc_i(flush), .cnt_o(flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk_i (clk), .rst_ni(rst), .inc_i(freeze), .cnt_o(wait_cnt_tot)
  );

endmodule
